// File: rtl/sound_play_seq.sv
// Playback sequencer: walks a sample ROM at a fixed tick rate and feeds samples to the PWM.
// Optional PAUSE_EN adds a pause_i level input that freezes the sample tick.
module sound_play_seq #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TICK_DIV = 8,
    parameter int unsigned ROM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              play_i,
    input  logic              stop_i,
    input  logic              loop_i,
`ifdef PAUSE_EN
    input  logic              pause_i,
`endif
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] len_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] sample_o,
    output logic              sample_valid_o,
    output logic              aud_en_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned FetchW = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;
    localparam logic [TickW-1:0]  TickReload = TickW'(TICK_DIV - 1);
    localparam logic [FetchW-1:0] FetchInit  = FetchW'(ROM_LAT);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StReady,
        StDrain
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]   next_q, next_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                aud_en_q, aud_en_d;
    logic                done_q, done_d;
    logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [FetchW-1:0]   fetch_cnt_q, fetch_cnt_d;

    logic paused;
    logic busy;
    logic tick;
    logic last_idx;

`ifdef PAUSE_EN
    assign paused = pause_i;
`else
    assign paused = 1'b0;
`endif

    assign busy     = (state_q != StIdle);
    assign tick     = (tick_cnt_q == '0) && !paused;
    assign last_idx = (idx_q == len_q - ADDR_W'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            start_q     <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            rom_addr_q  <= '0;
            next_q      <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            aud_en_q    <= 1'b0;
            done_q      <= 1'b0;
            tick_cnt_q  <= '0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            rom_addr_q  <= rom_addr_d;
            next_q      <= next_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            aud_en_q    <= aud_en_d;
            done_q      <= done_d;
            tick_cnt_q  <= tick_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        len_d       = len_q;
        idx_d       = idx_q;
        rom_addr_d  = rom_addr_q;
        next_d      = next_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        aud_en_d    = aud_en_q;
        done_d      = 1'b0;
        tick_cnt_d  = tick_cnt_q;
        fetch_cnt_d = fetch_cnt_q;

        // Free-running sample pacing; frozen only by pause.
        if (busy && !paused) begin
            tick_cnt_d = (tick_cnt_q == '0) ? TickReload : tick_cnt_q - TickW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (play_i && (len_i != '0)) begin
                    start_d     = start_addr_i;
                    len_d       = len_i;
                    idx_d       = '0;
                    rom_addr_d  = start_addr_i;
                    tick_cnt_d  = TickReload;
                    fetch_cnt_d = FetchInit;
                    state_d     = StFetch;
                end
            end
            StFetch: begin
                if (fetch_cnt_q == '0) begin
                    next_d  = rom_data_i;
                    state_d = StReady;
                end else begin
                    fetch_cnt_d = fetch_cnt_q - FetchW'(1);
                end
            end
            StReady: begin
                if (tick) begin
                    sample_d = next_q;
                    valid_d  = 1'b1;
                    aud_en_d = 1'b1;
                    if (!last_idx) begin
                        idx_d       = idx_q + ADDR_W'(1);
                        rom_addr_d  = rom_addr_q + ADDR_W'(1);
                        fetch_cnt_d = FetchInit;
                        state_d     = StFetch;
                    end else if (loop_i) begin
                        idx_d       = '0;
                        rom_addr_d  = start_q;
                        fetch_cnt_d = FetchInit;
                        state_d     = StFetch;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (tick) begin
                    done_d   = 1'b1;
                    aud_en_d = 1'b0;
                    sample_d = '0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides any tick or loop decision taken above.
        if (stop_i && busy) begin
            state_d  = StIdle;
            aud_en_d = 1'b0;
            sample_d = '0;
            valid_d  = 1'b0;
            done_d   = 1'b0;
        end
    end

    assign rom_addr_o     = rom_addr_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign aud_en_o       = aud_en_q;
    assign busy_o         = busy;
    assign done_o         = done_q;

endmodule

// File: doc/sound_play_seq.md
Name: sound_play_seq

Overview:
- Playback sequencer for the audio path: walks a sample ROM from a start address for a programmed length.
- Paces samples at a fixed tick rate and presents each sample, plus an enable, to the PWM modulator.
- Replaces the free-running address counter with start/stop/loop control and a done indication.
- Sits between the sample ROM and sound_new, in the divided audio clock domain.

Parameters:
ADDR_W, 16, ROM address and length width
DATA_W, 32, sample word width
TICK_DIV, 8, clk cycles per sample period; must be >= ROM_LAT+2
ROM_LAT, 1, ROM read latency in cycles (0 = combinational)

Ports:
clk  in  1  the single clock for the whole block
rstn  in  1  reset, asynchronous, active-low
play_i  in  1  single-cycle start request
stop_i  in  1  single-cycle abort request
loop_i  in  1  level; sampled at each end-of-buffer
start_addr_i  in  ADDR_W  first ROM address, latched on accept
len_i  in  ADDR_W  sample count, latched on accept
rom_addr_o  out  ADDR_W  ROM address
rom_data_i  in  DATA_W  ROM read data
sample_o  out  DATA_W  current sample to PWM
sample_valid_o  out  1  one-cycle strobe when sample_o updates
aud_en_o  out  1  PWM enable
busy_o  out  1  high whenever state is not IDLE
done_o  out  1  one-cycle strobe at normal end of playback

Behaviour:
- Reset values: all outputs 0; internal registers 0; state IDLE.
- States: IDLE, FETCH, READY, DRAIN.
- IDLE, play accept:
  - play_i=1 and len_i!=0 on edge E0 is an accept.
  - On accept: latch start and len; idx=0; rom_addr_o=start; tick_cnt=TICK_DIV-1; go FETCH.
  - play_i with len_i=0 is ignored.
  - play_i outside IDLE is ignored.
- Tick counter:
  - Decrements each cycle while busy; reloads TICK_DIV-1 after reaching 0.
  - tick = (tick_cnt==0).
- FETCH:
  - Lasts ROM_LAT+1 cycles.
  - On its last cycle, captures rom_data_i into next_r, then goes READY.
- READY, waits for tick. On the tick edge:
  - sample_o<=next_r; sample_valid_o=1 for that cycle; aud_en_o<=1.
  - If idx!=len-1: idx+1; rom_addr_o+1, wrapping modulo 2^ADDR_W; go FETCH.
  - If idx==len-1 and loop_i=1: idx=0; rom_addr_o=start; go FETCH.
  - If idx==len-1 and loop_i=0: go DRAIN.
- DRAIN:
  - Holds the last sample for one more tick period.
  - On the tick edge: done_o=1 for one cycle; aud_en_o<=0; sample_o<=0; go IDLE.
- Latency:
  - First sample_valid_o rises exactly TICK_DIV cycles after the accept edge.
  - Subsequent strobes are exactly TICK_DIV cycles apart, including across loop wrap.
- stop_i, from any non-IDLE state:
  - Next state IDLE; aud_en_o=0; sample_o=0; no done_o.
  - stop_i has priority over tick and over the loop decision in the same cycle.
  - stop_i in IDLE has no effect.
- len_i=1: one sample, then DRAIN (or repeated if loop_i=1).
- Reset asserted mid-playback forces the reset values immediately; no done_o is generated.

Optional Feature:
PAUSE_EN
- Defined:
  - Adds input pause_i (1 bit, level).
  - While pause_i=1 and busy: tick_cnt is frozen and no tick occurs.
  - sample_o and aud_en_o hold their values.
  - A FETCH in progress completes into READY, then waits.
  - Releasing pause resumes from the frozen tick_cnt.
  - stop_i still aborts while paused.
- Not defined: no pause_i port; the tick counter never freezes.

Test Plan:
1. TICK_DIV=8, ROM_LAT=1, ROM[a]=a*3, play start=0x10 len=4 loop=0 -> strobes at accept+8,16,24,32 with samples 0x30,0x33,0x36,0x39; done_o at accept+40; aud_en_o falls at the same edge; busy_o low after.
2. Same ROM, len=2, loop_i=1 -> sample sequence 0x30,0x33,0x30,0x33…, strobes every 8 cycles, no done_o; then loop_i=0 during the second 0x33 period -> done_o one tick after the next 0x33 strobe.
3. stop_i 3 cycles after the second strobe of scenario 1 -> next cycle state IDLE, aud_en_o=0, sample_o=0, no done_o; a following play accepts normally.
4. play with len_i=0 -> busy_o stays 0; play_i pulse while busy -> ignored, sequence unchanged.
5. start=0xFFFE, len=4 -> rom_addr_o sequence 0xFFFE,0xFFFF,0x0000,0x0001; rstn low mid-sequence -> all outputs 0 asynchronously.
6. PAUSE_EN: pause_i high for 20 cycles between strobes 1 and 2 -> strobe 2 delayed by exactly 20 cycles, sample_o held 0x30 throughout.
